// File: rtl/uart_cmd_comm_if.sv
// Handshake bundle between the serial front end (slave) and dig_core (master):
// assembled command words, response bytes and line status.
interface uart_cmd_comm_if;
    logic [23:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy;
    logic [7:0]  resp_data;
    logic        send_resp;
    logic        resp_sent;
    logic        tx_busy;
    logic        frm_err;

    modport master (
        input  cmd, cmd_rdy, resp_sent, tx_busy, frm_err,
        output clr_cmd_rdy, resp_data, send_resp
    );

    modport slave (
        output cmd, cmd_rdy, resp_sent, tx_busy, frm_err,
        input  clr_cmd_rdy, resp_data, send_resp
    );
endinterface

// File: rtl/uart_cmd_comm.sv
// Host-side 8N1 UART front end: packs three received bytes into a 24-bit command
// and serializes single response bytes, with RX and TX running fully independently.
module uart_cmd_comm #(
    parameter int BAUD_DIV     = 868,
    parameter int TIMEOUT_BITS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RX,
    output logic            TX,
    uart_cmd_comm_if.slave  host
);
    localparam int BW       = $clog2(BAUD_DIV);
    localparam int TO_LIMIT = TIMEOUT_BITS * BAUD_DIV;
    localparam int TW       = $clog2(TO_LIMIT + 1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(BAUD_DIV / 2 - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TO_LIMIT - 1);

    localparam logic [2:0] RX_IDLE  = 3'd0;
    localparam logic [2:0] RX_START = 3'd1;
    localparam logic [2:0] RX_DATA  = 3'd2;
    localparam logic [2:0] RX_STOP  = 3'd3;
    localparam logic [2:0] RX_WAIT  = 3'd4;

    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_START = 2'd1;
    localparam logic [1:0] TX_DATA  = 2'd2;
    localparam logic [1:0] TX_STOP  = 2'd3;

    logic          rxMeta_q, rxSync_q;
    logic [2:0]    rxState_q, rxState_d;
    logic [BW-1:0] rxCnt_q, rxCnt_d;
    logic [2:0]    rxBit_q, rxBit_d;
    logic [7:0]    rxShift_q, rxShift_d;
    logic          byteValid, frameErr;

    logic [23:0]   cmd_q, cmd_d;
    logic          cmdRdy_q, cmdRdy_d;
    logic [1:0]    byteCnt_q, byteCnt_d;
    logic [TW-1:0] toCnt_q, toCnt_d;
    logic          frmErr_q;

    logic [1:0]    txState_q, txState_d;
    logic [BW-1:0] txCnt_q, txCnt_d;
    logic [2:0]    txBit_q, txBit_d;
    logic [7:0]    txShift_q, txShift_d;
    logic          tx_q, tx_d;
    logic          txBusy_q, txBusy_d;
    logic          respSent_q, respSent_d;

    // Receiver runs only on the second synchronizer flop; the stop sample yields byteValid or frameErr.
    always_comb begin
        rxState_d = rxState_q;
        rxCnt_d   = rxCnt_q;
        rxBit_d   = rxBit_q;
        rxShift_d = rxShift_q;
        byteValid = 1'b0;
        frameErr  = 1'b0;
        case (rxState_q)
            RX_IDLE: begin
                if (!rxSync_q) begin
                    rxState_d = RX_START;
                    rxCnt_d   = '0;
                end
            end
            RX_START: begin
                if (rxCnt_q == HALF_LAST) begin
                    rxCnt_d   = '0;
                    rxBit_d   = '0;
                    rxState_d = rxSync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rxCnt_d = rxCnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rxCnt_q == BAUD_LAST) begin
                    rxCnt_d   = '0;
                    rxShift_d = {rxSync_q, rxShift_q[7:1]};
                    rxBit_d   = rxBit_q + 1'b1;
                    if (rxBit_q == 3'd7) rxState_d = RX_STOP;
                end else begin
                    rxCnt_d = rxCnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rxCnt_q == BAUD_LAST) begin
                    rxCnt_d = '0;
                    if (rxSync_q) begin
                        byteValid = 1'b1;
                        rxState_d = RX_IDLE;
                    end else begin
                        frameErr  = 1'b1;
                        rxState_d = RX_WAIT;
                    end
                end else begin
                    rxCnt_d = rxCnt_q + 1'b1;
                end
            end
            RX_WAIT: begin
                if (rxSync_q) rxState_d = RX_IDLE;
            end
            default: rxState_d = RX_IDLE;
        endcase
    end

    // Assembly ignores bytes while a command is pending; a stalled partial command ages out.
    always_comb begin
        cmd_d     = cmd_q;
        cmdRdy_d  = cmdRdy_q;
        byteCnt_d = byteCnt_q;
        toCnt_d   = toCnt_q;
        if (host.clr_cmd_rdy) cmdRdy_d = 1'b0;
        if (frameErr) begin
            byteCnt_d = 2'd0;
        end else if (byteValid && !cmdRdy_q) begin
            case (byteCnt_q)
                2'd0:    cmd_d[23:16] = rxShift_q;
                2'd1:    cmd_d[15:8]  = rxShift_q;
                default: cmd_d[7:0]   = rxShift_q;
            endcase
            if (byteCnt_q == 2'd2) begin
                byteCnt_d = 2'd0;
                cmdRdy_d  = 1'b1;
            end else begin
                byteCnt_d = byteCnt_q + 1'b1;
            end
        end
        if (rxState_q != RX_IDLE || byteCnt_q == 2'd0 || !rxSync_q) begin
            toCnt_d = '0;
        end else if (toCnt_q == TO_LAST) begin
            toCnt_d   = '0;
            byteCnt_d = 2'd0;
        end else begin
            toCnt_d = toCnt_q + 1'b1;
        end
    end

    // Transmitter drives the next line level one edge ahead so TX is a clean register output.
    always_comb begin
        txState_d  = txState_q;
        txCnt_d    = txCnt_q;
        txBit_d    = txBit_q;
        txShift_d  = txShift_q;
        tx_d       = tx_q;
        txBusy_d   = txBusy_q;
        respSent_d = 1'b0;
        case (txState_q)
            TX_IDLE: begin
                if (host.send_resp) begin
                    txShift_d = host.resp_data;
                    txBusy_d  = 1'b1;
                    tx_d      = 1'b0;
                    txCnt_d   = '0;
                    txState_d = TX_START;
                end
            end
            TX_START: begin
                if (txCnt_q == BAUD_LAST) begin
                    txCnt_d   = '0;
                    txBit_d   = '0;
                    tx_d      = txShift_q[0];
                    txShift_d = {1'b0, txShift_q[7:1]};
                    txState_d = TX_DATA;
                end else begin
                    txCnt_d = txCnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (txCnt_q == BAUD_LAST) begin
                    txCnt_d = '0;
                    if (txBit_q == 3'd7) begin
                        tx_d      = 1'b1;
                        txState_d = TX_STOP;
                    end else begin
                        tx_d      = txShift_q[0];
                        txShift_d = {1'b0, txShift_q[7:1]};
                        txBit_d   = txBit_q + 1'b1;
                    end
                end else begin
                    txCnt_d = txCnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (txCnt_q == BAUD_LAST) begin
                    txCnt_d    = '0;
                    respSent_d = 1'b1;
                    txBusy_d   = 1'b0;
                    txState_d  = TX_IDLE;
                end else begin
                    txCnt_d = txCnt_q + 1'b1;
                end
            end
            default: txState_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rxMeta_q   <= 1'b1;
            rxSync_q   <= 1'b1;
            rxState_q  <= RX_IDLE;
            rxCnt_q    <= '0;
            rxBit_q    <= '0;
            rxShift_q  <= '0;
            cmd_q      <= '0;
            cmdRdy_q   <= 1'b0;
            byteCnt_q  <= 2'd0;
            toCnt_q    <= '0;
            frmErr_q   <= 1'b0;
            txState_q  <= TX_IDLE;
            txCnt_q    <= '0;
            txBit_q    <= '0;
            txShift_q  <= '0;
            tx_q       <= 1'b1;
            txBusy_q   <= 1'b0;
            respSent_q <= 1'b0;
        end else begin
            rxMeta_q   <= RX;
            rxSync_q   <= rxMeta_q;
            rxState_q  <= rxState_d;
            rxCnt_q    <= rxCnt_d;
            rxBit_q    <= rxBit_d;
            rxShift_q  <= rxShift_d;
            cmd_q      <= cmd_d;
            cmdRdy_q   <= cmdRdy_d;
            byteCnt_q  <= byteCnt_d;
            toCnt_q    <= toCnt_d;
            frmErr_q   <= frameErr;
            txState_q  <= txState_d;
            txCnt_q    <= txCnt_d;
            txBit_q    <= txBit_d;
            txShift_q  <= txShift_d;
            tx_q       <= tx_d;
            txBusy_q   <= txBusy_d;
            respSent_q <= respSent_d;
        end
    end

    assign TX             = tx_q;
    assign host.cmd       = cmd_q;
    assign host.cmd_rdy   = cmdRdy_q;
    assign host.frm_err   = frmErr_q;
    assign host.tx_busy   = txBusy_q;
    assign host.resp_sent = respSent_q;
endmodule

// File: tb/tb_uart_cmd_comm.sv
// Directed bench for uart_cmd_comm at BAUD_DIV=16, TIMEOUT_BITS=4: command assembly,
// timeout, framing errors, response framing, full duplex and reset mid-frame.
module tb_uart_cmd_comm;
    localparam int BAUD = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rxLine = 1'b1;
    logic txLine;
    int   cyc = 0;
    int   checkCount = 0;
    int   passCount = 0;
    int   lastStartCyc = 0;
    int   rdyRiseCnt = 0, rdyRiseCyc = 0;
    int   frmErrCnt = 0, frmErrHigh = 0;
    int   respSentCnt = 0, respSentHigh = 0, respSentCyc = 0;
    logic prevRdy = 1'b0, prevFrm = 1'b0, prevSent = 1'b0;

    uart_cmd_comm_if hostIf ();

    uart_cmd_comm #(.BAUD_DIV(BAUD), .TIMEOUT_BITS(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .RX   (rxLine),
        .TX   (txLine),
        .host (hostIf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Edge/pulse bookkeeping observed mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (hostIf.cmd_rdy && !prevRdy) begin
            rdyRiseCnt++;
            rdyRiseCyc = cyc;
        end
        if (hostIf.frm_err && !prevFrm) frmErrCnt++;
        if (hostIf.frm_err) frmErrHigh++;
        if (hostIf.resp_sent && !prevSent) begin
            respSentCnt++;
            respSentCyc = cyc;
        end
        if (hostIf.resp_sent) respSentHigh++;
        prevRdy  = hostIf.cmd_rdy;
        prevFrm  = hostIf.frm_err;
        prevSent = hostIf.resp_sent;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        else
            passCount++;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        logic [9:0] frame;
        frame = {stopBit, data, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            rxLine = frame[i];
            if (i == 0) lastStartCyc = cyc + 1;
            repeat (BAUD - 1) @(negedge clk);
        end
    endtask

    task automatic clearCmd();
        @(negedge clk);
        hostIf.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        hostIf.clr_cmd_rdy = 1'b0;
        checkOutput("cmd_rdy_after_clr", 32'(hostIf.cmd_rdy), 32'd0);
    endtask

    // Samples TX mid-bit; optionally fires a second send_resp mid-frame that must be ignored.
    task automatic checkTxFrame(input logic [7:0] data, input logic injectBusy);
        int   e0, sentBefore, highBefore, guard;
        logic expBit;
        sentBefore = respSentCnt;
        highBefore = respSentHigh;
        @(negedge clk);
        hostIf.resp_data = data;
        hostIf.send_resp = 1'b1;
        e0 = cyc + 1;
        @(negedge clk);
        hostIf.send_resp = 1'b0;
        hostIf.resp_data = 8'h00;
        checkOutput("tx_busy_set", 32'(hostIf.tx_busy), 32'd1);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (i == 0) expBit = 1'b0;
            else if (i == 9) expBit = 1'b1;
            else expBit = data[i-1];
            checkOutput($sformatf("tx_bit%0d", i), 32'(txLine), 32'(expBit));
            if (injectBusy && i == 3) begin
                hostIf.resp_data = ~data;
                hostIf.send_resp = 1'b1;
            end
            if (i < 9) begin
                for (int k = 0; k < BAUD; k++) begin
                    @(negedge clk);
                    hostIf.send_resp = 1'b0;
                end
            end
        end
        guard = 0;
        while (respSentCnt == sentBefore && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        checkOutput("resp_sent_count", 32'(respSentCnt - sentBefore), 32'd1);
        checkOutput("resp_sent_width", 32'(respSentHigh - highBefore), 32'd1);
        checkOutput("resp_sent_time", 32'(respSentCyc - e0), 32'd160);
        checkOutput("tx_busy_clear", 32'(hostIf.tx_busy), 32'd0);
    endtask

    initial begin
        int frmBefore, frmHighBefore, sentBefore;
        hostIf.clr_cmd_rdy = 1'b0;
        hostIf.send_resp   = 1'b0;
        hostIf.resp_data   = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_tx", 32'(txLine), 32'd1);
        checkOutput("rst_cmd", 32'(hostIf.cmd), 32'd0);
        checkOutput("rst_cmd_rdy", 32'(hostIf.cmd_rdy), 32'd0);
        checkOutput("rst_resp_sent", 32'(hostIf.resp_sent), 32'd0);
        checkOutput("rst_tx_busy", 32'(hostIf.tx_busy), 32'd0);
        checkOutput("rst_frm_err", 32'(hostIf.frm_err), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h03, 1'b1);
        checkOutput("t1_cmd", 32'(hostIf.cmd), 32'h010203);
        checkOutput("t1_rdy_latency", 32'(rdyRiseCyc - lastStartCyc), 32'd154);

        applyStimulus(8'h44, 1'b1);
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'h66, 1'b1);
        checkOutput("t3_cmd_held", 32'(hostIf.cmd), 32'h010203);
        checkOutput("t3_rdy_held", 32'(hostIf.cmd_rdy), 32'd1);
        checkOutput("t3_no_new_rdy", 32'(rdyRiseCnt), 32'd1);
        clearCmd();

        applyStimulus(8'hAA, 1'b1);
        applyStimulus(8'hBB, 1'b1);
        repeat (5 * BAUD) @(negedge clk);
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h33, 1'b1);
        checkOutput("t2_cmd", 32'(hostIf.cmd), 32'h112233);
        checkOutput("t2_rdy", 32'(hostIf.cmd_rdy), 32'd1);
        clearCmd();

        frmBefore     = frmErrCnt;
        frmHighBefore = frmErrHigh;
        applyStimulus(8'h12, 1'b1);
        applyStimulus(8'h5A, 1'b0);
        @(negedge clk);
        rxLine = 1'b1;
        repeat (BAUD - 1) @(negedge clk);
        checkOutput("t4_frm_err_pulses", 32'(frmErrCnt - frmBefore), 32'd1);
        checkOutput("t4_frm_err_width", 32'(frmErrHigh - frmHighBefore), 32'd1);
        checkOutput("t4_rdy_low", 32'(hostIf.cmd_rdy), 32'd0);
        applyStimulus(8'h77, 1'b1);
        applyStimulus(8'h88, 1'b1);
        applyStimulus(8'h99, 1'b1);
        checkOutput("t4_cmd", 32'(hostIf.cmd), 32'h778899);
        clearCmd();

        checkTxFrame(8'hA5, 1'b1);

        fork
            begin
                applyStimulus(8'hC1, 1'b1);
                applyStimulus(8'hC2, 1'b1);
                applyStimulus(8'hC3, 1'b1);
            end
            checkTxFrame(8'h3C, 1'b0);
        join
        checkOutput("t6_cmd", 32'(hostIf.cmd), 32'hC1C2C3);
        checkOutput("t6_rdy", 32'(hostIf.cmd_rdy), 32'd1);

        sentBefore = respSentCnt;
        @(negedge clk);
        hostIf.resp_data = 8'hF0;
        hostIf.send_resp = 1'b1;
        @(negedge clk);
        hostIf.send_resp = 1'b0;
        repeat (50) @(negedge clk);
        checkOutput("t6_tx_low_before_rst", 32'(txLine), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("t6_rst_tx", 32'(txLine), 32'd1);
        checkOutput("t6_rst_busy", 32'(hostIf.tx_busy), 32'd0);
        checkOutput("t6_rst_cmd", 32'(hostIf.cmd), 32'd0);
        checkOutput("t6_rst_rdy", 32'(hostIf.cmd_rdy), 32'd0);
        repeat (200) @(negedge clk);
        checkOutput("t6_no_resp_sent", 32'(respSentCnt - sentBefore), 32'd0);

        applyStimulus(8'hD1, 1'b1);
        applyStimulus(8'hD2, 1'b1);
        applyStimulus(8'hD3, 1'b1);
        checkOutput("t6_post_rst_cmd", 32'(hostIf.cmd), 32'hD1D2D3);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
